iiitb_sqd_sched: RTL

Round-robin scheduler that shares one serial "1010"-style pattern-detection engine among NUM_CH byte requesters. Each granted byte is serialized MSB first through the detector. A per-channel history register preserves detector context across bytes, so overlapping matches that span two bytes of the same channel are found even when other channels' bytes are interleaved between them. The block sits between byte-wide producers and the match-reporting logic, replacing one detector instance per channel.

---
 rtl/iiitb_sqd_pkg.sv | 20 ++
 rtl/iiitb_sqd_sched_if.sv | 33 +++
 rtl/iiitb_sqd_rr_arb.sv | 43 ++++
 rtl/iiitb_sqd_sched.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/iiitb_sqd_pkg.sv
`default_nettype none
// =====================================================================
// iiitb_sqd_pkg : shared types and constants for the shared-detector scheduler
// Rev 1.0
// =====================================================================
package iiitb_sqd_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int                  c_byte_w      = 8;
    localparam int                  c_idx_w       = 3;
    localparam int                  c_def_pat_len = 4;
    localparam logic [c_def_pat_len-1:0] c_def_pat = 4'b1010;
    localparam int                  c_cnt_w       = 8;

endpackage
`default_nettype wire

// File: rtl/iiitb_sqd_sched_if.sv
`default_nettype none
// =====================================================================
// iiitb_sqd_sched_if : byte-request and match-report bus of the scheduler
// Rev 1.0
// =====================================================================
interface iiitb_sqd_sched_if #(
    parameter int NUM_CH = 4
);
    import iiitb_sqd_pkg::*;

    localparam int c_ch_w = $clog2(NUM_CH);

    logic [NUM_CH-1:0]          req_valid;
    logic [NUM_CH*c_byte_w-1:0] req_data;
    logic [NUM_CH-1:0]          req_ready;
    logic                       flush;
    logic                       match_valid;
    logic [c_ch_w-1:0]          match_ch;
    logic [c_idx_w-1:0]         match_pos;
    logic                       busy;

    modport master (
        output req_valid, req_data, flush,
        input  req_ready, match_valid, match_ch, match_pos, busy
    );

    modport slave (
        input  req_valid, req_data, flush,
        output req_ready, match_valid, match_ch, match_pos, busy
    );

endinterface
`default_nettype wire

// File: rtl/iiitb_sqd_rr_arb.sv
`default_nettype none
// =====================================================================
// iiitb_sqd_rr_arb : round-robin pick of the first valid channel after last_grant
// Rev 1.0
// =====================================================================
module iiitb_sqd_rr_arb #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = $clog2(NUM_CH)
) (
    input  wire logic [NUM_CH-1:0] req_valid,
    input  wire logic [CH_W-1:0]   last_grant,
    output logic      [NUM_CH-1:0] grant,
    output logic      [CH_W-1:0]   grant_idx,
    output logic                   grant_any
);

    logic [CH_W:0]   w_sum;
    logic [CH_W-1:0] w_idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        w_sum     = '0;
        w_idx     = '0;
        // Scan farthest-first so the nearest valid channel after last_grant overwrites.
        for (int i = NUM_CH; i >= 1; i--) begin
            w_sum = {1'b0, last_grant} + (CH_W+1)'(i);
            if (w_sum >= (CH_W+1)'(NUM_CH)) begin
                w_sum = w_sum - (CH_W+1)'(NUM_CH);
            end
            w_idx = w_sum[CH_W-1:0];
            if (req_valid[w_idx]) begin
                grant        = '0;
                grant[w_idx] = 1'b1;
                grant_idx    = w_idx;
                grant_any    = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/iiitb_sqd_sched.sv
`default_nettype none
// =====================================================================
// iiitb_sqd_sched : one serial pattern detector shared round-robin by NUM_CH byte channels
// Optional per-channel match counters: IIITB_SQD_MATCH_CNT_EN.  Rev 1.0
// =====================================================================
module iiitb_sqd_sched
    import iiitb_sqd_pkg::*;
#(
    parameter int                 NUM_CH  = 4,
    parameter int                 PAT_LEN = c_def_pat_len,
    parameter logic [PAT_LEN-1:0] PAT     = PAT_LEN'(c_def_pat)
) (
    input  wire logic             clk,
    input  wire logic             reset,
    iiitb_sqd_sched_if.slave      bus
`ifdef IIITB_SQD_MATCH_CNT_EN
    ,
    input  wire logic [$clog2(NUM_CH)-1:0] cnt_sel,
    output logic      [c_cnt_w-1:0]        cnt_out
`endif
);

    localparam int c_ch_w   = $clog2(NUM_CH);
    localparam int c_hist_w = PAT_LEN - 1;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_byte_w-1:0]  r_byte;
    logic [c_ch_w-1:0]    r_cur_ch;
    logic [c_ch_w-1:0]    r_last_grant;
    logic [c_idx_w-1:0]   r_bit_idx;
    logic [c_hist_w-1:0]  r_hist [NUM_CH];
    logic                 r_match_valid;
    logic [c_ch_w-1:0]    r_match_ch;
    logic [c_idx_w-1:0]   r_match_pos;

    logic [NUM_CH-1:0]    w_grant;
    logic [c_ch_w-1:0]    w_grant_idx;
    logic                 w_grant_any;
    logic                 w_take;
    logic [PAT_LEN-1:0]   w_win;
    logic                 w_hit;

    iiitb_sqd_rr_arb #(
        .NUM_CH (NUM_CH),
        .CH_W   (c_ch_w)
    ) u_arb (
        .req_valid  (bus.req_valid),
        .last_grant (r_last_grant),
        .grant      (w_grant),
        .grant_idx  (w_grant_idx),
        .grant_any  (w_grant_any)
    );

    // Gating with reset keeps the combinational ready low while reset is held.
    assign w_take = reset && !bus.flush && (r_state == IDLE) && w_grant_any;
    assign w_win  = {r_hist[r_cur_ch], r_byte[r_bit_idx]};
    assign w_hit  = (r_state == SHIFT) && !bus.flush && (w_win == PAT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        bus.req_ready = '0;
        unique case (r_state)
            IDLE: begin
                if (w_take) begin
                    w_state_nxt   = SHIFT;
                    bus.req_ready = w_grant;
                end
            end
            SHIFT: begin
                if (bus.flush || (r_bit_idx == '0)) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_byte        <= '0;
            r_cur_ch      <= '0;
            r_last_grant  <= c_ch_w'(NUM_CH - 1);
            r_bit_idx     <= '0;
            r_match_valid <= 1'b0;
            r_match_ch    <= '0;
            r_match_pos   <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_hist[i] <= '0;
            end
        end else begin
            r_match_valid <= w_hit;
            if (w_hit) begin
                r_match_ch  <= r_cur_ch;
                r_match_pos <= r_bit_idx;
            end
            if (bus.flush) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    r_hist[i] <= '0;
                end
            end else if (r_state == SHIFT) begin
                r_hist[r_cur_ch] <= w_win[c_hist_w-1:0];
            end
            if (w_take) begin
                r_byte       <= bus.req_data[w_grant_idx*c_byte_w +: c_byte_w];
                r_cur_ch     <= w_grant_idx;
                r_last_grant <= w_grant_idx;
                r_bit_idx    <= '1;
            end else if (r_state == SHIFT) begin
                r_bit_idx <= r_bit_idx - 1'b1;
            end
        end
    end

    assign bus.match_valid = r_match_valid;
    assign bus.match_ch    = r_match_ch;
    assign bus.match_pos   = r_match_pos;
    assign bus.busy        = (r_state == SHIFT);

`ifdef IIITB_SQD_MATCH_CNT_EN
    logic [c_cnt_w-1:0] r_cnt [NUM_CH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_cnt[i] <= '0;
            end
        end else if (bus.flush) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_cnt[i] <= '0;
            end
        end else if (w_hit && (r_cnt[r_cur_ch] != '1)) begin
            r_cnt[r_cur_ch] <= r_cnt[r_cur_ch] + 1'b1;
        end
    end

    assign cnt_out = (32'(cnt_sel) < NUM_CH) ? r_cnt[cnt_sel] : '0;
`endif

endmodule
`default_nettype wire
